// File: rtl/nrisc_int_pkg.sv
// rtl/nrisc_int_pkg.sv - shared types and constants for the NRISC-Aurora interrupt controller
package nrisc_int_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SIGNAL  = 2'd1,
    SERVICE = 2'd2
  } int_state_t;

  localparam logic [1:0] ADDR_MASK = 2'd0;
  localparam logic [1:0] ADDR_EDGE = 2'd1;
  localparam logic [1:0] ADDR_PEND = 2'd2;
  localparam logic [1:0] ADDR_BASE = 2'd3;

  localparam int N_IRQ_DEF = 8;
  localparam int VEC_W_DEF = 8;
  localparam int TAM       = 16;
  localparam int N_IData   = 8;

endpackage

// File: rtl/nrisc_int_sync.sv
// rtl/nrisc_int_sync.sv - two-flop synchroniser with rising-edge detect for one request line
module nrisc_int_sync (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic level,
  output logic rise
);

  logic s1, s2, s3;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= din;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign level = s2;
  assign rise  = s2 & ~s3;

endmodule

// File: rtl/nrisc_int_ctrl.sv
// rtl/nrisc_int_ctrl.sv - config registers, pending logic, priority encoder and dispatch FSM
module nrisc_int_ctrl
  import nrisc_int_pkg::*;
#(
  parameter int N_IRQ = N_IRQ_DEF,
  parameter int VEC_W = VEC_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_IRQ-1:0] irq_in,
  input  logic             eoi,
  input  logic             cfg_write,
  input  logic [1:0]       cfg_addr,
  input  logic [7:0]       cfg_wdata,
  output logic [7:0]       cfg_rdata,
  output logic             INTERRUPT_flag,
  output logic [VEC_W-1:0] INTERRUPT_ch,
  output logic             int_busy
);

  localparam int IDX_W = (N_IRQ > 1) ? $clog2(N_IRQ) : 1;

  int_state_t       state, state_nxt;
  logic [N_IRQ-1:0] mask_q, edge_q, pend_q, lvl_q;
  logic [N_IRQ-1:0] sync_lvl, sync_rise;
  logic [N_IRQ-1:0] pending, cand, set_v, clr_v, win_onehot;
  logic [7:0]       base_q;
  logic [IDX_W-1:0] win_idx, win_q;
  logic [VEC_W-1:0] ch_q;
  logic             any_cand, wr_mask, wr_edge, wr_pend, wr_base;

  for (genvar g = 0; g < N_IRQ; g++) begin : g_sync
    nrisc_int_sync u_sync (
      .clk   (clk),
      .rst   (rst),
      .din   (irq_in[g]),
      .level (sync_lvl[g]),
      .rise  (sync_rise[g])
    );
  end

  assign wr_mask = cfg_write && (cfg_addr == ADDR_MASK);
  assign wr_edge = cfg_write && (cfg_addr == ADDR_EDGE);
  assign wr_pend = cfg_write && (cfg_addr == ADDR_PEND);
  assign wr_base = cfg_write && (cfg_addr == ADDR_BASE);

  // Level lines are re-registered so both modes share the same request-to-flag latency.
  assign pending  = (pend_q & edge_q) | (lvl_q & ~edge_q);
  assign cand     = pending & mask_q;
  assign any_cand = |cand;

  always_comb begin
    win_onehot        = '0;
    win_onehot[win_q] = 1'b1;
    set_v             = sync_rise & edge_q;
    clr_v             = '0;
    if (wr_pend) clr_v = clr_v | cfg_wdata[N_IRQ-1:0];
    if (wr_edge) clr_v = clr_v | (edge_q ^ cfg_wdata[N_IRQ-1:0]);
    if (state == SIGNAL) clr_v = clr_v | win_onehot;
  end

  always_comb begin
    win_idx = '0;
    for (int i = N_IRQ - 1; i >= 0; i--) begin
      if (cand[i]) win_idx = IDX_W'(i);
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (any_cand) state_nxt = SIGNAL;
      SIGNAL:  state_nxt = SERVICE;
      SERVICE: if (eoi) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      mask_q <= '0;
      edge_q <= '0;
      base_q <= '0;
      pend_q <= '0;
      lvl_q  <= '0;
      win_q  <= '0;
      ch_q   <= '0;
    end else begin
      state <= state_nxt;
      if (wr_mask) mask_q <= cfg_wdata[N_IRQ-1:0];
      if (wr_edge) edge_q <= cfg_wdata[N_IRQ-1:0];
      if (wr_base) base_q <= cfg_wdata;
      // A fresh edge wins over any clear landing in the same cycle.
      pend_q <= (pend_q & ~clr_v) | set_v;
      lvl_q  <= sync_lvl;
      if (state == IDLE && any_cand) begin
        win_q <= win_idx;
        ch_q  <= VEC_W'(base_q) + VEC_W'(win_idx);
      end
    end
  end

  always_comb begin
    cfg_rdata = '0;
    case (cfg_addr)
      ADDR_MASK: cfg_rdata[N_IRQ-1:0] = mask_q;
      ADDR_EDGE: cfg_rdata[N_IRQ-1:0] = edge_q;
      ADDR_PEND: cfg_rdata[N_IRQ-1:0] = pending;
      default:   cfg_rdata            = base_q;
    endcase
  end

  assign INTERRUPT_flag = (state == SIGNAL);
  assign int_busy       = (state == SERVICE);
  assign INTERRUPT_ch   = ch_q;

endmodule

// File: tb/tb_nrisc_int_ctrl.sv
// tb/tb_nrisc_int_ctrl.sv - self-checking bench for nrisc_int_ctrl
module tb_nrisc_int_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] irq_in;
  logic       eoi;
  logic       cfg_write;
  logic [1:0] cfg_addr;
  logic [7:0] cfg_wdata;
  logic [7:0] cfg_rdata;
  logic       INTERRUPT_flag;
  logic [7:0] INTERRUPT_ch;
  logic       int_busy;

  int errors = 0;
  int checks = 0;

  nrisc_int_ctrl #(.N_IRQ(8), .VEC_W(8)) dut (
    .clk            (clk),
    .rst            (rst),
    .irq_in         (irq_in),
    .eoi            (eoi),
    .cfg_write      (cfg_write),
    .cfg_addr       (cfg_addr),
    .cfg_wdata      (cfg_wdata),
    .cfg_rdata      (cfg_rdata),
    .INTERRUPT_flag (INTERRUPT_flag),
    .INTERRUPT_ch   (INTERRUPT_ch),
    .int_busy       (int_busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       wr;
    logic [1:0] addr;
    logic [7:0] wdata;
    logic [7:0] exp;
  } vec_t;

  vec_t vt[9];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic wr(input logic [1:0] a, input logic [7:0] d);
    cfg_write = 1'b1;
    cfg_addr  = a;
    cfg_wdata = d;
    @(negedge clk);
    cfg_write = 1'b0;
  endtask

  task automatic rd(input logic [1:0] a, output logic [7:0] d);
    cfg_addr = a;
    #1 d = cfg_rdata;
  endtask

  task automatic wait_flag(input int maxc, output int lat);
    lat = -1;
    for (int c = 1; c <= maxc; c++) begin
      @(negedge clk);
      if (INTERRUPT_flag) begin
        lat = c;
        break;
      end
    end
  endtask

  task automatic pulse_meas(input logic [7:0] v, input int maxc, output int lat);
    irq_in = v;
    lat = -1;
    for (int c = 1; c <= maxc; c++) begin
      @(negedge clk);
      if (c == 1) irq_in = '0;
      if (INTERRUPT_flag) begin
        lat = c;
        break;
      end
    end
  endtask

  // Called at the negedge where the flag was seen; moves into SERVICE and returns via eoi.
  task automatic service_eoi(input string name);
    @(negedge clk);
    chk({name, "_busy"}, 32'(int_busy), 32'd1);
    chk({name, "_flag_1cyc"}, 32'(INTERRUPT_flag), 32'd0);
    eoi = 1'b1;
    @(negedge clk);
    eoi = 1'b0;
    chk({name, "_idle"}, 32'(int_busy), 32'd0);
  endtask

  initial begin
    logic [7:0] r;
    logic [7:0] base, m, p;
    int lat;
    logic [7:0] expq[$];

    rst = 1'b1; irq_in = '0; eoi = 1'b0;
    cfg_write = 1'b0; cfg_addr = '0; cfg_wdata = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_flag", 32'(INTERRUPT_flag), 32'd0);
    chk("rst_busy", 32'(int_busy), 32'd0);
    chk("rst_ch", 32'(INTERRUPT_ch), 32'd0);

    vt[0] = '{1'b0, 2'd0, 8'h00, 8'h00};
    vt[1] = '{1'b0, 2'd1, 8'h00, 8'h00};
    vt[2] = '{1'b0, 2'd2, 8'h00, 8'h00};
    vt[3] = '{1'b0, 2'd3, 8'h00, 8'h00};
    vt[4] = '{1'b1, 2'd0, 8'hA5, 8'hA5};
    vt[5] = '{1'b1, 2'd1, 8'h0F, 8'h0F};
    vt[6] = '{1'b1, 2'd3, 8'h7F, 8'h7F};
    vt[7] = '{1'b1, 2'd0, 8'h3C, 8'h3C};
    vt[8] = '{1'b0, 2'd1, 8'h00, 8'h0F};
    for (int i = 0; i < 9; i++) begin
      if (vt[i].wr) wr(vt[i].addr, vt[i].wdata);
      rd(vt[i].addr, r);
      chk($sformatf("reg_vec%0d", i), 32'(r), 32'(vt[i].exp));
    end
    chk("reg_no_flag", 32'(INTERRUPT_flag), 32'd0);

    // Single edge request, latency and vector
    @(negedge clk);
    wr(2'd0, 8'hFF); wr(2'd1, 8'hFF); wr(2'd3, 8'h20);
    pulse_meas(8'h08, 10, lat);
    chk("t1_latency", 32'(lat), 32'd4);
    chk("t1_ch", 32'(INTERRUPT_ch), 32'h23);
    @(negedge clk);
    rd(2'd2, r);
    chk("t1_pend_cleared", 32'(r), 32'h00);
    chk("t1_busy", 32'(int_busy), 32'd1);
    repeat (3) @(negedge clk);
    chk("t1_busy_hold", 32'(int_busy), 32'd1);
    chk("t1_no_nest", 32'(INTERRUPT_flag), 32'd0);
    eoi = 1'b1;
    @(negedge clk);
    eoi = 1'b0;
    chk("t1_eoi_idle", 32'(int_busy), 32'd0);

    // Two simultaneous edges: priority then deferred dispatch
    pulse_meas(8'h22, 10, lat);
    chk("t2_latency", 32'(lat), 32'd4);
    chk("t2_first_ch", 32'(INTERRUPT_ch), 32'h21);
    service_eoi("t2a");
    wait_flag(1, lat);
    chk("t2_second_lat", 32'(lat), 32'd1);
    chk("t2_second_ch", 32'(INTERRUPT_ch), 32'h25);
    service_eoi("t2b");

    // Masked request stays pending, then dispatches on unmask
    wr(2'd0, 8'h00);
    pulse_meas(8'h04, 8, lat);
    chk("t3_masked_noflag", 32'(lat), 32'hFFFFFFFF);
    rd(2'd2, r);
    chk("t3_pend", 32'(r), 32'h04);
    wr(2'd0, 8'h04);
    wait_flag(1, lat);
    chk("t3_unmask_lat", 32'(lat), 32'd1);
    chk("t3_ch", 32'(INTERRUPT_ch), 32'h22);
    service_eoi("t3");

    // Level mode with vector wrap and redispatch
    wr(2'd1, 8'h00); wr(2'd3, 8'hFE); wr(2'd0, 8'h10);
    irq_in = 8'h10;
    wait_flag(10, lat);
    chk("t4_latency", 32'(lat), 32'd4);
    chk("t4_wrap_ch", 32'(INTERRUPT_ch), 32'h02);
    rd(2'd2, r);
    chk("t4_pend_level", 32'(r), 32'h10);
    service_eoi("t4a");
    wait_flag(1, lat);
    chk("t4_redispatch", 32'(lat), 32'd1);
    irq_in = 8'h00;
    repeat (5) @(negedge clk);
    chk("t4_busy_hold", 32'(int_busy), 32'd1);
    eoi = 1'b1;
    @(negedge clk);
    eoi = 1'b0;
    wait_flag(10, lat);
    chk("t4_dropped_noflag", 32'(lat), 32'hFFFFFFFF);

    // PEND write-1-clear racing a new edge on the same line
    wr(2'd1, 8'hFF); wr(2'd0, 8'h00);
    irq_in = 8'h40;
    @(negedge clk);
    irq_in = 8'h00;
    repeat (4) @(negedge clk);
    rd(2'd2, r);
    chk("t5_pend_set", 32'(r), 32'h40);
    irq_in = 8'h40;
    @(negedge clk);
    irq_in = 8'h00;
    @(negedge clk);
    cfg_write = 1'b1; cfg_addr = 2'd2; cfg_wdata = 8'h40;
    @(negedge clk);
    cfg_write = 1'b0;
    rd(2'd2, r);
    chk("t5_set_wins", 32'(r), 32'h40);
    wr(2'd2, 8'h40);
    rd(2'd2, r);
    chk("t5_w1c", 32'(r), 32'h00);

    // Reset during SERVICE
    wr(2'd0, 8'hFF); wr(2'd3, 8'h40);
    pulse_meas(8'h01, 10, lat);
    chk("t6_latency", 32'(lat), 32'd4);
    @(negedge clk);
    chk("t6_busy", 32'(int_busy), 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("t6_rst_busy", 32'(int_busy), 32'd0);
    chk("t6_rst_flag", 32'(INTERRUPT_flag), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    for (int a = 0; a < 4; a++) begin
      rd(2'(a), r);
      chk($sformatf("t6_reg%0d", a), 32'(r), 32'h00);
    end
    chk("t6_ch", 32'(INTERRUPT_ch), 32'h00);
    eoi = 1'b1;
    @(negedge clk);
    eoi = 1'b0;
    wait_flag(6, lat);
    chk("t6_eoi_noflag", 32'(lat), 32'hFFFFFFFF);
    chk("t6_eoi_busy", 32'(int_busy), 32'd0);

    // Randomised rounds: dispatch order is ascending index over unmasked pulsed lines
    wr(2'd1, 8'hFF);
    for (int rnd = 0; rnd < 20; rnd++) begin
      base = 8'($urandom);
      m    = 8'($urandom);
      p    = 8'($urandom_range(1, 255));
      wr(2'd3, base);
      wr(2'd0, m);
      expq.delete();
      for (int i = 0; i < 8; i++) if (p[i] && m[i]) expq.push_back(base + 8'(i));
      pulse_meas(p, 8, lat);
      if (expq.size() == 0) begin
        chk($sformatf("rnd%0d_noflag", rnd), 32'(lat), 32'hFFFFFFFF);
      end else begin
        chk($sformatf("rnd%0d_lat", rnd), 32'(lat), 32'd4);
        chk($sformatf("rnd%0d_ch", rnd), 32'(INTERRUPT_ch), 32'(expq.pop_front()));
        service_eoi($sformatf("rnd%0d", rnd));
        while (expq.size() > 0) begin
          wait_flag(4, lat);
          chk($sformatf("rnd%0d_next_lat", rnd), 32'(lat), 32'd1);
          chk($sformatf("rnd%0d_next_ch", rnd), 32'(INTERRUPT_ch), 32'(expq.pop_front()));
          service_eoi($sformatf("rnd%0d_n", rnd));
        end
        wait_flag(8, lat);
        chk($sformatf("rnd%0d_drained", rnd), 32'(lat), 32'hFFFFFFFF);
      end
      rd(2'd2, r);
      chk($sformatf("rnd%0d_pend", rnd), 32'(r), 32'(p & ~m));
      wr(2'd2, 8'hFF);
      rd(2'd2, r);
      chk($sformatf("rnd%0d_pend_clr", rnd), 32'(r), 32'h00);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
